jtdsp16_yaau: RTL and testbench
===============================

Name: jtdsp16_yaau

Overview:
- Y-space address arithmetic unit and data RAM for the DSP16 core.
- Holds pointer registers r0-r3, circular-buffer bounds rb/re and increment j. Generates the data RAM address and applies post-modification to the selected pointer.
- Owns the internal data RAM array. Its registered read port is the ram_dout bus consumed by the data arithmetic unit; the write port takes the store data that unit produces.
- Sits directly upstream of the DAU on the RAM data path.

Parameters:
- AW, 11, data RAM address width; pointer, rb and re registers are AW bits wide.
- DEPTH, 2048, number of 16-bit RAM words; must equal 2**AW.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active low
- cen  input  1  clock enable; all state updates qualified by it
- ptr_en  input  1  RAM access this cycle using the selected pointer
- ptr_sel  input  2  pointer select: 0..3 = r0..r3
- ptr_mode  input  2  post-modify: 0 none, 1 +1, 2 -1, 3 +j
- ram_we  input  1  with ptr_en: write ram_din; otherwise read
- ram_din  input  16  store data from DAU (accumulator or register readback)
- reg_load  input  1  load register selected by reg_sel
- reg_sel  input  3  0..3 r0..r3, 4 rb, 5 re, 6 j, 7 reserved
- reg_din  input  16  load data (immediate or RAM value)
- ram_addr  output  AW  current RAM address
- ram_dout  output  16  registered RAM read data, to DAU
- reg_dout  output  16  readback of register selected by reg_sel

Behaviour:
- Reset (rst_n low, asynchronous):
  - r0-r3, rb, re, j and ram_dout clear to 0.
  - RAM contents are not reset.
  - Reset asserted mid-access aborts the access; no write occurs after reset assertion.
- cen low: no register, pointer or RAM state changes; ram_dout holds.
- ram_addr:
  - Combinational: r[ptr_sel], valid whenever ptr_en is high.
  - Always reflects the pre-modification pointer value.
- Write: on a cen edge with ptr_en && ram_we, mem[ram_addr] <= ram_din. ram_dout unchanged.
- Read:
  - On a cen edge with ptr_en && !ram_we, ram_dout <= mem[ram_addr]. Latency is 1 cen cycle.
  - ram_dout holds until the next read.
  - A read in the cycle after a write to the same address returns the new data.
- Post-modify, applied on the same edge as the access, only when ptr_en:
  - mode 0: pointer unchanged.
  - mode 1: if re != 0 and pointer == re, pointer <= rb (circular wrap); else pointer + 1.
  - mode 2: pointer - 1.
  - mode 3: pointer + j, with j a 16-bit two's complement value.
  - Circular wrap applies to mode 1 only.
  - All arithmetic is modulo 2**AW: 0 - 1 = 2**AW-1; 2**AW-1 + 1 = 0 when not circular.
- Register load:
  - On a cen edge with reg_load: r0-r3, rb and re take reg_din[AW-1:0]; j takes all 16 bits.
  - reg_sel 7 is ignored.
- Simultaneous load and post-modify of the same pointer: the load wins and the modification is discarded. The access itself still uses the old pointer value.
- Load of a different register in the same cycle as a post-modify: both take effect.
- Load of rb, re or j in the same cycle as a post-modify: the post-modify uses the old rb/re/j values.
- reg_dout:
  - Combinational; pointers, rb and re are zero-extended to 16 bits.
  - j is returned as 16 bits; reg_sel 7 returns 0.
- ram_we without ptr_en has no effect.

Test Plan:
- Reset then reads: rst_n low, then read via r0 mode 0 -> ram_addr=0, reg_dout=0 for every reg_sel, ram_dout=mem[0] one cycle after the read.
- Write/read-back: load r1=0x010, write 0xBEEF with mode 1, load r1=0x010 again, read with mode 0 -> ram_dout=0xBEEF next cycle, r1=0x010.
- Circular buffer: rb=0x020, re=0x023, r2=0x020; four reads in mode 1 -> addresses 0x020,0x021,0x022,0x023, then r2=0x020. With re=0 the same sequence ends with r2=0x024.
- Increment j and wrap: j=0xFFFE, r3=0x001, mode 3 -> r3=0x7FF. Mode 2 from r0=0 -> r0=0x7FF. Mode 1 from 0x7FF with re=0 -> 0.
- Load/modify collision: r0=0x005, same cycle reg_load r0 with 0x100 and ptr_en mode 1 on r0 -> access at 0x005, then r0=0x100.
- cen gating and mid-op reset: cen low for 3 cycles during ptr_en+ram_we -> memory, pointers and ram_dout unchanged. rst_n pulsed low mid-sequence -> all registers and ram_dout are 0 immediately.

Source files
------------

// File: rtl/jtdsp16_yaau.sv
// Y-space address arithmetic unit for the DSP16 core.
// Holds pointers r0-r3, circular bounds rb/re and the signed increment j,
// drives the data RAM address from the selected pointer and owns the data RAM.
// The registered read port (ram_dout) feeds the data arithmetic unit.
module jtdsp16_yaau #(
  parameter int AW    = 11,
  parameter int DEPTH = 2048
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          ptr_en,
  input  logic [1:0]    ptr_sel,
  input  logic [1:0]    ptr_mode,
  input  logic          ram_we,
  input  logic [15:0]   ram_din,
  input  logic          reg_load,
  input  logic [2:0]    reg_sel,
  input  logic [15:0]   reg_din,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_dout,
  output logic [15:0]   reg_dout
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0]      ptr      [4];
  logic [AW-1:0]      ptr_next [4];
  logic [AW-1:0]      rb, re;
  logic [AW-1:0]      rb_next, re_next;
  logic signed [15:0] j;
  logic signed [15:0] j_next;
  logic [15:0]        mem [DEPTH];
  logic [AW-1:0]      mod_ptr;
  logic               do_read;
  logic               do_write;

  // Post-modification of a pointer. Wrap to rb only applies to +1 when re is
  // non-zero; every other result simply wraps modulo 2**AW.
  function automatic logic [AW-1:0] post_modify(
    input logic [AW-1:0]      p,
    input logic [1:0]         mode,
    input logic [AW-1:0]      b,
    input logic [AW-1:0]      e,
    input logic signed [15:0] inc
  );
    logic [AW-1:0] res;
    case (mode)
      2'd0:    res = p;
      2'd1:    res = ((e != '0) && (p == e)) ? b : p + ONE;
      2'd2:    res = p - ONE;
      default: res = p + AW'(inc);
    endcase
    return res;
  endfunction

  // The access always uses the pointer value before any modification.
  assign ram_addr = ptr[ptr_sel];
  assign mod_ptr  = post_modify(ram_addr, ptr_mode, rb, re, j);
  assign do_read  = cen & ptr_en & ~ram_we;
  // Write strobe is killed while reset is held so an aborted access never lands.
  assign do_write = cen & ptr_en & ram_we & rst_n;

  // Next register values: post-modify first, then an explicit load overrides it.
  always_comb begin
    for (int i = 0; i < 4; i++) ptr_next[i] = ptr[i];
    rb_next = rb;
    re_next = re;
    j_next  = j;
    if (cen && ptr_en) ptr_next[ptr_sel] = mod_ptr;
    if (cen && reg_load) begin
      case (reg_sel)
        3'd0, 3'd1, 3'd2, 3'd3: ptr_next[reg_sel[1:0]] = reg_din[AW-1:0];
        3'd4:    rb_next = reg_din[AW-1:0];
        3'd5:    re_next = reg_din[AW-1:0];
        3'd6:    j_next  = reg_din;
        default: ;
      endcase
    end
  end

  // Address unit register file with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ptr[i] <= '0;
      rb <= '0;
      re <= '0;
      j  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) ptr[i] <= ptr_next[i];
      rb <= rb_next;
      re <= re_next;
      j  <= j_next;
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[ram_addr] <= ram_din;
  end

  // Registered read port towards the DAU; holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_dout <= '0;
    end else if (do_read) begin
      ram_dout <= mem[ram_addr];
    end
  end

  // Register readback, zero-extending the address-width registers.
  always_comb begin
    reg_dout = '0;
    case (reg_sel)
      3'd0, 3'd1, 3'd2, 3'd3: reg_dout = 16'(ptr[reg_sel[1:0]]);
      3'd4:    reg_dout = 16'(rb);
      3'd5:    reg_dout = 16'(re);
      3'd6:    reg_dout = j;
      default: reg_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Self-checking bench for jtdsp16_yaau: directed scenarios plus randomized
// traffic, all compared against a behavioural model of pointers and RAM.
module tb_jtdsp16_yaau;

  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          cen      = 1'b1;
  logic          ptr_en   = 1'b0;
  logic [1:0]    ptr_sel  = '0;
  logic [1:0]    ptr_mode = '0;
  logic          ram_we   = 1'b0;
  logic [15:0]   ram_din  = '0;
  logic          reg_load = 1'b0;
  logic [2:0]    reg_sel  = '0;
  logic [15:0]   reg_din  = '0;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_dout;
  logic [15:0]   reg_dout;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int          m_r [4];
  int          m_rb, m_re;
  logic [15:0] m_j;
  logic [15:0] m_dout;
  logic [15:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  jtdsp16_yaau #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .ptr_en   (ptr_en),
    .ptr_sel  (ptr_sel),
    .ptr_mode (ptr_mode),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .reg_load (reg_load),
    .reg_sel  (reg_sel),
    .reg_din  (reg_din),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .reg_dout (reg_dout)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_reg(input logic [2:0] rs);
    case (rs)
      3'd0, 3'd1, 3'd2, 3'd3: return 16'(m_r[rs[1:0]]);
      3'd4:    return 16'(m_rb);
      3'd5:    return 16'(m_re);
      3'd6:    return m_j;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_rb = 0; m_re = 0; m_j = '0; m_dout = '0;
  endtask

  // Apply one clock edge to the model from the current inputs.
  task automatic model_edge();
    int p, np;
    if (!rst_n || !cen) return;
    if (ptr_en) begin
      p = m_r[ptr_sel];
      if (ram_we) m_mem[p] = ram_din;
      else        m_dout = m_mem[p];
      case (ptr_mode)
        2'd0:    np = p;
        2'd1:    np = (m_re != 0 && p == m_re) ? m_rb : (p + 1) % DEPTH;
        2'd2:    np = (p - 1 + DEPTH) % DEPTH;
        default: np = (p + int'($signed(m_j))) & (DEPTH - 1);
      endcase
      m_r[ptr_sel] = np;
    end
    if (reg_load) begin
      case (reg_sel)
        3'd0, 3'd1, 3'd2, 3'd3: m_r[reg_sel[1:0]] = int'(reg_din) & (DEPTH - 1);
        3'd4:    m_rb = int'(reg_din) & (DEPTH - 1);
        3'd5:    m_re = int'(reg_din) & (DEPTH - 1);
        3'd6:    m_j  = reg_din;
        default: ;
      endcase
    end
  endtask

  // One cycle: check combinational outputs, clock, then check ram_dout.
  task automatic tick();
    #1;
    if (ptr_en) check_eq("ram_addr", 16'(ram_addr), 16'(m_r[ptr_sel]));
    check_eq("reg_dout", reg_dout, model_reg(reg_sel));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("ram_dout", ram_dout, m_dout);
  endtask

  task automatic peek(input logic [2:0] rs, output logic [15:0] v);
    reg_sel = rs;
    #1;
    v = reg_dout;
  endtask

  task automatic load(input logic [2:0] rs, input logic [15:0] val);
    ptr_en = 1'b0; reg_load = 1'b1; reg_sel = rs; reg_din = val;
    tick();
    reg_load = 1'b0;
  endtask

  task automatic access(input logic [1:0] sel, input logic [1:0] mode,
                        input logic we, input logic [15:0] din);
    reg_load = 1'b0; ptr_en = 1'b1; ptr_sel = sel; ptr_mode = mode;
    ram_we = we; ram_din = din;
    tick();
    ptr_en = 1'b0; ram_we = 1'b0;
  endtask

  // Reset asserted in the middle of a pending write.
  task automatic pulse_reset(input logic [15:0] din);
    ptr_en = 1'b1; ram_we = 1'b1; ptr_sel = 2'd0; ptr_mode = 2'd1; ram_din = din;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_dout", ram_dout, 16'h0000);
    for (int rs = 0; rs < 7; rs++) begin
      reg_sel = 3'(rs);
      #1;
      check_eq("rst_mid_reg", reg_dout, 16'h0000);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    ptr_en = 1'b0; ram_we = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] old;

    // Reset state
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int rs = 0; rs < 8; rs++) begin
      reg_sel = 3'(rs);
      #1;
      check_eq("rst_reg", reg_dout, 16'h0000);
    end
    check_eq("rst_dout", ram_dout, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole RAM through r0 with +1, wrapping back to 0
    for (int i = 0; i < DEPTH; i++) access(2'd0, 2'd1, 1'b1, 16'($urandom));
    peek(3'd0, v); check_eq("fill_wrap_r0", v, 16'h0000);

    // Read via r0 mode 0 right after the fill
    access(2'd0, 2'd0, 1'b0, 16'h0000);
    check_eq("rd0_dout", ram_dout, m_mem[0]);

    // Write then read back
    load(3'd1, 16'h0010);
    access(2'd1, 2'd1, 1'b1, 16'hBEEF);
    load(3'd1, 16'h0010);
    access(2'd1, 2'd0, 1'b0, 16'h0000);
    check_eq("wr_rd_dout", ram_dout, 16'hBEEF);
    peek(3'd1, v); check_eq("wr_rd_r1", v, 16'h0010);

    // Circular buffer with re != 0
    load(3'd4, 16'h0020);
    load(3'd5, 16'h0023);
    load(3'd2, 16'h0020);
    for (int k = 0; k < 4; k++) begin
      peek(3'd2, v); check_eq("circ_addr", v, 16'(32'h20 + k));
      access(2'd2, 2'd1, 1'b0, 16'h0000);
    end
    peek(3'd2, v); check_eq("circ_wrap", v, 16'h0020);

    // Same sequence with re = 0 runs linearly
    load(3'd5, 16'h0000);
    load(3'd2, 16'h0020);
    for (int k = 0; k < 4; k++) access(2'd2, 2'd1, 1'b0, 16'h0000);
    peek(3'd2, v); check_eq("lin_end", v, 16'h0024);

    // Signed j increment and modular wraps
    load(3'd6, 16'hFFFE);
    load(3'd3, 16'h0001);
    access(2'd3, 2'd3, 1'b0, 16'h0000);
    peek(3'd3, v); check_eq("j_wrap", v, 16'h07FF);
    load(3'd0, 16'h0000);
    access(2'd0, 2'd2, 1'b0, 16'h0000);
    peek(3'd0, v); check_eq("dec_wrap", v, 16'h07FF);
    access(2'd0, 2'd1, 1'b0, 16'h0000);
    peek(3'd0, v); check_eq("inc_wrap", v, 16'h0000);

    // Load and post-modify of the same pointer in one cycle
    load(3'd0, 16'h0005);
    reg_load = 1'b1; reg_sel = 3'd0; reg_din = 16'h0100;
    ptr_en = 1'b1; ptr_sel = 2'd0; ptr_mode = 2'd1; ram_we = 1'b0;
    #1;
    check_eq("coll_addr", 16'(ram_addr), 16'h0005);
    tick();
    reg_load = 1'b0; ptr_en = 1'b0;
    peek(3'd0, v); check_eq("coll_r0", v, 16'h0100);

    // cen low during a pending write
    load(3'd1, 16'h0030);
    old = m_mem[16'h0030];
    cen = 1'b0;
    ptr_en = 1'b1; ptr_sel = 2'd1; ptr_mode = 2'd1; ram_we = 1'b1; ram_din = ~old;
    for (int k = 0; k < 3; k++) tick();
    cen = 1'b1; ptr_en = 1'b0; ram_we = 1'b0;
    peek(3'd1, v); check_eq("cen_r1", v, 16'h0030);
    access(2'd1, 2'd0, 1'b0, 16'h0000);
    check_eq("cen_mem", ram_dout, old);

    // Reset mid-write, then confirm the write target was left intact
    load(3'd0, 16'h0000);
    old = m_mem[0];
    pulse_reset(~old);
    access(2'd0, 2'd0, 1'b0, 16'h0000);
    check_eq("rst_nowrite", ram_dout, old);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cen      = ($urandom_range(0, 7) != 0);
      ptr_en   = ($urandom_range(0, 3) != 0);
      ptr_sel  = 2'($urandom_range(0, 3));
      ptr_mode = 2'($urandom_range(0, 3));
      ram_we   = ($urandom_range(0, 2) == 0);
      ram_din  = 16'($urandom);
      reg_load = ($urandom_range(0, 3) == 0);
      reg_sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) reg_din = 16'($urandom_range(16'h20, 16'h27));
      else                           reg_din = 16'($urandom);
      tick();
    end
    cen = 1'b1; ptr_en = 1'b0; reg_load = 1'b0; ram_we = 1'b0;
    for (int rs = 0; rs < 8; rs++) begin
      peek(3'(rs), v);
      check_eq("final_reg", v, model_reg(3'(rs)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
